// File: rtl/sram_queue_pkg.sv
// Shared sizing constants for the two-port SRAM queue controller.
//   Q_DATA_W / Q_DEPTH / Q_ADDR_W : default entry width, macro depth, address width
//   OBUF_DEPTH / OBUF_CNT_W       : output buffer depth and its occupancy width
package sram_queue_pkg;

    localparam int Q_DATA_W   = 128;
    localparam int Q_DEPTH    = 16;
    localparam int Q_ADDR_W   = 4;
    localparam int OBUF_DEPTH = 2;
    localparam int OBUF_CNT_W = 2;

endpackage

// File: rtl/sram_queue_obuf.sv
// Two-entry output buffer that catches the macro's registered read data.
//   clock, reset  : clock, asynchronous active-high reset
//   push_i        : capture push_data_i this edge
//   pop_i         : consumer took the head this edge
//   valid_o       : head entry present
//   head_o        : head entry data
//   cnt_o         : occupancy 0..2
module sram_queue_obuf
    import sram_queue_pkg::*;
#(
    parameter int DATA_W = Q_DATA_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     head_o,
    output logic [OBUF_CNT_W-1:0] cnt_o
);

    logic [DATA_W-1:0]     mem_q [OBUF_DEPTH];
    logic                  wr_idx_q, wr_idx_d;
    logic                  rd_idx_q, rd_idx_d;
    logic [OBUF_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_idx_d = ~wr_idx_q;
        end
        if (pop_i) begin
            rd_idx_d = ~rd_idx_q;
        end
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data slots carry no reset; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_idx_q] <= push_data_i;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign head_o  = mem_q[rd_idx_q];
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sram_2p_queue_ctrl.sv
// Ready/valid queue controller driving a two-port SRAM macro. Entries are
// written through the macro write port, read back through the read port and
// land in a 2-entry output buffer that hides the one-cycle read latency.
//   clock, reset            : sole clock, asynchronous active-high reset
//   enq_valid/ready/bits    : producer side
//   deq_valid/ready/bits    : consumer side
//   count                   : total occupancy (macro + in-flight + buffer)
//   sram_web/aa/d           : macro write port (enable active-low)
//   sram_reb/ab, sram_q     : macro read port (enable active-low), read data
module sram_2p_queue_ctrl
    import sram_queue_pkg::*;
#(
    parameter int DATA_W = Q_DATA_W,
    parameter int DEPTH  = Q_DEPTH,
    parameter int ADDR_W = Q_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_bits,
    output logic [ADDR_W+1:0] count,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_aa,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_reb,
    output logic [ADDR_W-1:0] sram_ab,
    input  logic [DATA_W-1:0] sram_q
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       sram_cnt_q, sram_cnt_d;
    logic                  ren_q;
    logic                  enq_fire, deq_fire, rd_fire;
    logic [OBUF_CNT_W-1:0] obuf_cnt;
    logic [2:0]            obuf_claim;

    // enq_ready looks only at registered macro occupancy; reset gates it low.
    assign enq_ready = !reset && (sram_cnt_q != FULL_CNT);
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    // Buffer slots already claimed next cycle: held entries plus the read
    // landing now, minus the one leaving. A read may issue only if one is free.
    assign obuf_claim = 3'(obuf_cnt) + 3'(ren_q) - 3'(deq_fire);
    assign rd_fire    = (sram_cnt_q != '0) && (obuf_claim < 3'(OBUF_DEPTH));

    assign sram_web = ~enq_fire;
    assign sram_aa  = wr_ptr_q;
    assign sram_d   = enq_bits;
    assign sram_reb = ~rd_fire;
    assign sram_ab  = rd_ptr_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sram_cnt_d = sram_cnt_q;
        if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (enq_fire && !rd_fire) begin
            sram_cnt_d = sram_cnt_q + 1'b1;
        end else if (!enq_fire && rd_fire) begin
            sram_cnt_d = sram_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_cnt_q <= '0;
            ren_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            ren_q      <= rd_fire;
        end
    end

    sram_queue_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clock       (clock),
        .reset       (reset),
        .push_i      (ren_q),
        .push_data_i (sram_q),
        .pop_i       (deq_fire),
        .valid_o     (deq_valid),
        .head_o      (deq_bits),
        .cnt_o       (obuf_cnt)
    );

    assign count = (ADDR_W+2)'(sram_cnt_q) + (ADDR_W+2)'(ren_q) + (ADDR_W+2)'(obuf_cnt);

endmodule

// File: tb/tb_sram_2p_queue_ctrl.sv
module tb_sram_2p_queue_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         enq_valid;
    logic         enq_ready;
    logic [127:0] enq_bits;
    logic         deq_valid;
    logic         deq_ready;
    logic [127:0] deq_bits;
    logic [5:0]   count;
    logic         sram_web;
    logic [3:0]   sram_aa;
    logic [127:0] sram_d;
    logic         sram_reb;
    logic [3:0]   sram_ab;
    logic [127:0] sram_q;

    sram_2p_queue_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (enq_bits),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_bits  (deq_bits),
        .count     (count),
        .sram_web  (sram_web),
        .sram_aa   (sram_aa),
        .sram_d    (sram_d),
        .sram_reb  (sram_reb),
        .sram_ab   (sram_ab),
        .sram_q    (sram_q)
    );

    always #5 clock = ~clock;

    // Macro model: registered read, garbage on cycles without a read.
    logic [127:0] mem_m [16];
    always @(posedge clock) begin
        if (!sram_web) mem_m[sram_aa] <= sram_d;
        if (!sram_reb) sram_q <= mem_m[sram_ab];
        else           sram_q <= {$urandom, $urandom, $urandom, $urandom};
    end

    int           passed = 0;
    int           total  = 0;
    logic [127:0] sb [$];
    logic [3:0]   wr_addr_m = '0;
    logic [3:0]   rd_addr_m = '0;
    int           deq_cnt = 0;
    logic [127:0] last_deq = '0;
    logic         stall_prev = 1'b0;
    logic [127:0] prev_bits = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Per-cycle monitor, called at the negedge before the active edge.
    task automatic mon();
        chk("count", 128'(count), 128'(sb.size()));
        chk("web", 128'(sram_web), 128'(!(enq_valid && enq_ready)));
        if (stall_prev) begin
            chk("deq_stable_v", 128'(deq_valid), 128'(1));
            chk("deq_stable_d", deq_bits, prev_bits);
        end
        if (!sram_web) begin
            chk("wr_addr", 128'(sram_aa), 128'(wr_addr_m));
            chk("wr_data", sram_d, enq_bits);
            wr_addr_m++;
            sb.push_back(enq_bits);
        end
        if (!sram_reb) begin
            chk("rd_addr", 128'(sram_ab), 128'(rd_addr_m));
            rd_addr_m++;
        end
        if (deq_valid && deq_ready) begin
            if (sb.size() == 0) chk("deq_extra", 128'(1), 128'(0));
            else                chk("deq_data", deq_bits, sb.pop_front());
            deq_cnt++;
            last_deq = deq_bits;
        end
        stall_prev = deq_valid && !deq_ready;
        prev_bits  = deq_bits;
    endtask

    task automatic half();
        @(negedge clock);
    endtask

    task automatic fin();
        mon();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc();
        half();
        fin();
    endtask

    task automatic enq_one(input logic [127:0] data);
        logic acc;
        acc = 1'b0;
        enq_valid = 1'b1;
        enq_bits  = data;
        for (int k = 0; k < 40 && !acc; k++) begin
            half();
            acc = enq_ready;
            fin();
        end
        if (!acc) chk("enq_timeout", 128'(0), 128'(1));
        enq_valid = 1'b0;
    endtask

    task automatic drain();
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int k = 0; k < 300 && sb.size() != 0; k++) cyc();
        chk("drain_done", 128'(sb.size()), 128'(0));
        half();
        chk("empty_valid", 128'(deq_valid), 128'(0));
        fin();
        deq_ready = 1'b0;
    endtask

    initial begin
        int           d0;
        logic [127:0] nxt;
        logic         fired;

        reset     = 1'b1;
        enq_valid = 1'b1;
        enq_bits  = '0;
        deq_ready = 1'b0;
        #3;
        chk("rst_enq_ready", 128'(enq_ready), 128'(0));
        chk("rst_deq_valid", 128'(deq_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_web", 128'(sram_web), 128'(1));
        chk("rst_reb", 128'(sram_reb), 128'(1));
        @(posedge clock);
        @(posedge clock);
        #1;
        enq_valid = 1'b0;
        reset     = 1'b0;
        half();
        chk("post_rst_ready", 128'(enq_ready), 128'(1));
        fin();

        // Single entry latency
        enq_valid = 1'b1;
        enq_bits  = 128'h1;
        half();
        chk("single_web", 128'(sram_web), 128'(0));
        chk("single_aa", 128'(sram_aa), 128'(0));
        fin();
        enq_valid = 1'b0;
        half();
        chk("single_reb", 128'(sram_reb), 128'(0));
        chk("single_ab", 128'(sram_ab), 128'(0));
        chk("single_v1", 128'(deq_valid), 128'(0));
        fin();
        half();
        chk("single_v2", 128'(deq_valid), 128'(0));
        fin();
        half();
        chk("single_v3", 128'(deq_valid), 128'(1));
        chk("single_bits", deq_bits, 128'h1);
        fin();
        drain();

        // Fill to capacity, then drain with pointer wrap
        for (int i = 0; i < 18; i++) enq_one(128'(i));
        cyc();
        cyc();
        enq_valid = 1'b1;
        enq_bits  = 128'hBAD;
        half();
        chk("full_ready", 128'(enq_ready), 128'(0));
        chk("full_count", 128'(count), 128'(18));
        fin();
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        half();
        chk("full_rd_issue", 128'(sram_reb), 128'(0));
        chk("full_ready_hold", 128'(enq_ready), 128'(0));
        fin();
        half();
        chk("full_ready_rise", 128'(enq_ready), 128'(1));
        fin();
        drain();

        // Streaming
        d0        = deq_cnt;
        nxt       = 128'h1000;
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            enq_bits = nxt;
            half();
            fired = enq_ready;
            if (i >= 3) chk("stream_gap", 128'(deq_valid), 128'(1));
            fin();
            if (fired) nxt++;
        end
        chk("stream_deqs", 128'(deq_cnt - d0), 128'(97));
        drain();

        // Random backpressure
        for (int i = 0; i < 300; i++) begin
            enq_valid = ($urandom_range(0, 99) < 70);
            enq_bits  = {$urandom, $urandom, $urandom, $urandom};
            deq_ready = ($urandom_range(0, 99) < 30);
            cyc();
        end
        drain();

        // Simultaneous enq and read at sram_cnt = DEPTH-1
        for (int i = 0; i < 17; i++) enq_one(128'(32'h200 + i));
        cyc();
        cyc();
        cyc();
        enq_valid = 1'b1;
        enq_bits  = 128'h2FF;
        deq_ready = 1'b1;
        half();
        chk("simul_ready", 128'(enq_ready), 128'(1));
        chk("simul_reb", 128'(sram_reb), 128'(0));
        fin();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        half();
        chk("simul_ready_after", 128'(enq_ready), 128'(1));
        chk("simul_count", 128'(count), 128'(17));
        fin();
        enq_one(128'h300);
        half();
        chk("simul_full", 128'(enq_ready), 128'(0));
        fin();
        drain();

        // Reset mid-stream with a read in flight
        for (int i = 0; i < 10; i++) enq_one(128'(100 + i));
        cyc();
        cyc();
        cyc();
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        enq_bits  = 128'h5;
        reset     = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(deq_valid), 128'(0));
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_web", 128'(sram_web), 128'(1));
        chk("mid_rst_reb", 128'(sram_reb), 128'(1));
        chk("mid_rst_ready", 128'(enq_ready), 128'(0));
        sb.delete();
        wr_addr_m  = '0;
        rd_addr_m  = '0;
        stall_prev = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        enq_valid = 1'b0;
        reset     = 1'b0;
        d0        = deq_cnt;
        enq_one(128'hA);
        drain();
        chk("rst_first_cnt", 128'(deq_cnt - d0), 128'(1));
        chk("rst_first_data", last_deq, 128'hA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_2p_queue_ctrl.md
# sram_2p_queue_ctrl

Synchronous ready/valid queue controller that is the initiator side of the 16x128 two-port SRAM macro: it drives the macro's write port (active-low write enable, write address, data) and read port (active-low read enable, read address), and absorbs the macro's one-cycle registered read latency with a 2-entry output buffer. It sits between a producer and a consumer in the frontend/cache datapath. Storage lives in the macro; the block holds only pointers, counters and the output buffer.

## Interface
- DATA_W, 128, entry width; must match macro Bits
- DEPTH, 16, macro word count; power of two
- ADDR_W, 4, log2(DEPTH)
- clock  in  1  sole clock; also drives macro write and read clocks
- reset  in  1  asynchronous, active-high
- enq_valid  in  1  producer has data
- enq_ready  out  1  high when sram_cnt < DEPTH; registered-state only, no path from deq side
- enq_bits  in  DATA_W  enqueue data
- deq_valid  out  1  output buffer head valid
- deq_ready  in  1  consumer accepts
- deq_bits  out  DATA_W  output buffer head
- count  out  ADDR_W+2  total occupancy (sram_cnt + inflight + obuf_cnt)
- sram_web  out  1  macro write enable, active-low
- sram_aa  out  ADDR_W  macro write address
- sram_d  out  DATA_W  macro write data
- sram_reb  out  1  macro read enable, active-low
- sram_ab  out  ADDR_W  macro read address
- sram_q  in  DATA_W  macro read data, valid the cycle after sram_reb low, garbage otherwise

## Operation
- enq_fire = enq_valid & enq_ready; sram_web = ~enq_fire; sram_aa = wr_ptr; sram_d = enq_bits (combinational).
- wr_ptr/rd_ptr ADDR_W bits, wrap DEPTH-1 -> 0; sram_cnt 0..DEPTH counts entries written but not yet read.
- deq_fire = deq_valid & deq_ready.
- Read issue rd_fire = (sram_cnt != 0) & (obuf_cnt + ren_q - deq_fire < 2); sram_reb = ~rd_fire; sram_ab = rd_ptr.
- ren_q = rd_fire registered; when ren_q is high, sram_q is pushed into the output buffer at that edge.
- sram_cnt next = sram_cnt + enq_fire - rd_fire; simultaneous enq and read leaves it unchanged.
- An entry written at edge t is readable from cycle t+1 (sram_cnt updated at t). The same-address same-cycle read-old-data hazard therefore cannot occur.
- Output buffer: 2-entry FIFO; push on ren_q, pop on deq_fire, both allowed in the same cycle. The issue credit guarantees a push never finds it full.
- Total capacity DEPTH+2; enq_ready depends only on sram_cnt.
- No enq->deq bypass; every entry passes through the macro.

## Timing
- Reset (async assert): wr_ptr, rd_ptr, sram_cnt, ren_q and obuf_cnt = 0; deq_valid = 0, count = 0, sram_web = 1, sram_reb = 1. enq_ready = 0 while reset is high, 1 in the first cycle after deassert.
- Reset mid-operation discards all entries and any in-flight read. Macro contents are not cleared and are never exposed.
- Latency: enq_fire in cycle 0 on an empty queue gives the write at edge 0, sram_reb low in cycle 1, ren_q high in cycle 2, and deq_valid high in cycle 3 with deq_bits = enq_bits.
- Throughput: 1 entry/cycle sustained with enq_valid and deq_ready both held high.
- Full: count = DEPTH+2 and sram_cnt = DEPTH, so enq_ready = 0; it rises the cycle after the next rd_fire.
- Empty: deq_valid = 0 whenever obuf_cnt = 0, regardless of sram_cnt.
- deq_bits is held stable while deq_valid & ~deq_ready.

## Structure
- Package sram_queue_pkg: DATA_W/DEPTH/ADDR_W defaults and the OBUF_DEPTH = 2 constant.
- One sub-module, sram_queue_obuf: the 2-entry output buffer (push/pop/count/head). The macro is instantiated by the parent alongside this block, not inside it.

## Test plan
- Single entry: after reset, enq 0x1 in cycle 0 -> sram_web low cycle 0 addr 0; sram_reb low cycle 1 addr 0; deq_valid cycle 3 with 0x1.
- Fill: deq_ready = 0, enq 18 entries 0..17 -> enq_ready falls after the 18th accepted, count = 18. Drain -> 0..17 in order, sram_ab wraps 15 -> 0.
- Streaming: enq_valid = deq_ready = 1 for 100 cycles, incrementing data -> after 3-cycle fill, one deq per cycle with no gaps or reorder.
- Backpressure: random deq_ready at 30% -> no loss or duplication, deq_bits stable while stalled, sram_q never captured when sram_reb was high.
- Simultaneous: at sram_cnt = DEPTH-1, enq and read in the same cycle -> sram_cnt stays DEPTH-1 and enq_ready stays 1.
- Reset mid-stream with 10 entries queued and a read in flight -> all outputs reach reset values immediately. A following enq of 0xA is the first deq.
